// File: rtl/data_mem_responder.sv
// Latency-modelled byte-addressed little-endian data RAM behind valid/ready request/response handshakes.
// Define DMEM_BACK_TO_BACK_EN to accept the next request in the same cycle the response retires.
module data_mem_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned AW    = ADDR_WIDTH;
    localparam int unsigned CW    = 4;
    localparam int unsigned NB    = DW / 8;
    localparam int unsigned WORDS = 2 ** (AW - 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [2:0]    funct3_q, funct3_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [DW-1:0] mem_q [WORDS];

    logic [DW-1:0] word_c, byte_sh_c, half_sh_c, ld_c, lanes_c;
    logic [NB-1:0] be_c;
    logic          err_c, mem_we_c, accept_c;
    logic [7:0]    byte_c;
    logic [15:0]   half_c;

    // Upper address bits alias onto the decoded range.
    logic unused_addr;
    assign unused_addr = ^req_addr[DW-1:AW];

    always_comb begin
        req_ready = (state_q == S_IDLE);
`ifdef DMEM_BACK_TO_BACK_EN
        if (state_q == S_RESP) req_ready = rsp_ready;
`endif
    end

    assign accept_c  = req_valid && req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Lane select, extension, byte enables and alignment/funct3 checks for the captured request.
    always_comb begin
        word_c    = mem_q[addr_q[AW-1:2]];
        byte_sh_c = word_c >> {addr_q[1:0], 3'b000};
        half_sh_c = word_c >> {addr_q[1], 4'b0000};
        byte_c    = byte_sh_c[7:0];
        half_c    = half_sh_c[15:0];
        err_c     = 1'b0;
        ld_c      = '0;
        lanes_c   = '0;
        be_c      = '0;
        if (we_q) begin
            case (funct3_q)
                3'b000: begin
                    be_c    = NB'(1) << addr_q[1:0];
                    lanes_c = {NB{wdata_q[7:0]}};
                end
                3'b001: begin
                    err_c   = addr_q[0];
                    be_c    = addr_q[1] ? NB'(4'b1100) : NB'(4'b0011);
                    lanes_c = {(NB/2){wdata_q[15:0]}};
                end
                3'b010: begin
                    err_c   = |addr_q[1:0];
                    be_c    = '1;
                    lanes_c = wdata_q;
                end
                default: err_c = 1'b1;
            endcase
        end else begin
            case (funct3_q)
                3'b000: ld_c = {{(DW-8){byte_c[7]}}, byte_c};
                3'b100: ld_c = {{(DW-8){1'b0}}, byte_c};
                3'b001: begin
                    err_c = addr_q[0];
                    ld_c  = {{(DW-16){half_c[15]}}, half_c};
                end
                3'b101: begin
                    err_c = addr_q[0];
                    ld_c  = {{(DW-16){1'b0}}, half_c};
                end
                3'b010: begin
                    err_c = |addr_q[1:0];
                    ld_c  = word_c;
                end
                default: err_c = 1'b1;
            endcase
        end
    end

    // A reset edge coinciding with the commit edge suppresses the write.
    assign mem_we_c = rst_n && (state_q == S_WAIT) && (cnt_q == '0) && we_q && !err_c;

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (be_c[i]) mem_q[addr_q[AW-1:2]][8*i +: 8] <= lanes_c[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: ;
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_c;
                    rsp_rdata_d = (we_q || err_c) ? '0 : ld_c;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Accept is only possible from IDLE, or from a retiring RESP in back-to-back mode.
        if (accept_c) begin
            state_d  = S_WAIT;
            cnt_d    = CW'(LATENCY - 1);
            we_d     = req_we;
            addr_d   = req_addr[AW-1:0];
            wdata_d  = req_wdata;
            funct3_d = req_funct3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus queues expected responses, a monitor checks them.
module tb_data_mem_responder;

    localparam int LAT = 2;
`ifdef DMEM_BACK_TO_BACK_EN
    localparam int EXP_GAP = LAT + 1;
`else
    localparam int EXP_GAP = LAT + 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
        int          lat;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   last_rsp_cyc = 0;
    int   checks = 0;
    int   fails = 0;

    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each response transfer pops one expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_rsp: rdata 0x%08h err %0d with empty scoreboard", rsp_rdata, rsp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                if (e.lat != 0) chk("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                if (e.gap != 0) chk("rsp_spacing", 32'(cyc - last_rsp_cyc), 32'(e.gap));
            end
            last_rsp_cyc = cyc;
        end
    end

    // Drives one request until accepted; garbage is driven afterwards to show inputs are ignored.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input logic [31:0] er, input logic ee,
                         input int lat, input int gap, input bit push);
        int  n = 0;
        bit  done = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        while (!done) begin
            @(negedge clk);
            if (req_ready) begin
                done = 1;
                if (push) exp_q.push_back('{er, ee, cyc, lat, gap});
            end else if (++n > 50) begin
                checks++; fails++;
                $display("FAIL accept_timeout: req_ready never high for addr 0x%08h", addr);
                done = 1;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A; req_funct3 = 3'b111;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); n++;
        end
        if (exp_q.size() != 0) begin
            checks++; fails++;
            $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // Basic word store/load with latency check
        issue(1, 32'h010, 32'hDEADBEEF, 3'b010, 32'h0, 0, LAT + 1, 0, 1); drain();
        issue(0, 32'h010, 32'h0, 3'b010, 32'hDEADBEEF, 0, LAT + 1, 0, 1); drain();
        // Byte lane store and extensions
        issue(1, 32'h013, 32'h00000080, 3'b000, 32'h0, 0, 0, 0, 1); drain();
        issue(0, 32'h010, 32'h0, 3'b010, 32'h80ADBEEF, 0, 0, 0, 1); drain();
        issue(0, 32'h013, 32'h0, 3'b000, 32'hFFFFFF80, 0, 0, 0, 1); drain();
        issue(0, 32'h013, 32'h0, 3'b100, 32'h00000080, 0, 0, 0, 1); drain();
        issue(0, 32'h010, 32'h0, 3'b000, 32'hFFFFFFEF, 0, 0, 0, 1); drain();
        // Halfword store and extensions
        issue(1, 32'h012, 32'h1234ABCD, 3'b001, 32'h0, 0, 0, 0, 1); drain();
        issue(0, 32'h010, 32'h0, 3'b010, 32'hABCDBEEF, 0, 0, 0, 1); drain();
        issue(0, 32'h012, 32'h0, 3'b001, 32'hFFFFABCD, 0, 0, 0, 1); drain();
        issue(0, 32'h012, 32'h0, 3'b101, 32'h0000ABCD, 0, 0, 0, 1); drain();
        issue(0, 32'h010, 32'h0, 3'b101, 32'h0000BEEF, 0, 0, 0, 1); drain();
        // Errors: misaligned, illegal funct3; memory untouched
        issue(1, 32'h011, 32'h0BADF00D, 3'b010, 32'h0, 1, LAT + 1, 0, 1); drain();
        issue(0, 32'h013, 32'h0, 3'b001, 32'h0, 1, 0, 0, 1); drain();
        issue(0, 32'h012, 32'h0, 3'b010, 32'h0, 1, 0, 0, 1); drain();
        issue(0, 32'h010, 32'h0, 3'b011, 32'h0, 1, 0, 0, 1); drain();
        issue(1, 32'h010, 32'hFFFFFFFF, 3'b011, 32'h0, 1, 0, 0, 1); drain();
        issue(0, 32'h010, 32'h0, 3'b010, 32'hABCDBEEF, 0, 0, 0, 1); drain();
        // Address aliasing above ADDR_WIDTH
        issue(0, 32'h0000_1010, 32'h0, 3'b010, 32'hABCDBEEF, 0, 0, 0, 1); drain();

        // Response stall: output held, no new request accepted
        rsp_ready = 1'b0;
        issue(0, 32'h010, 32'h0, 3'b010, 32'hABCDBEEF, 0, 0, 0, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
        chk("stall_valid_seen", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_rdata", rsp_rdata, 32'hABCDBEEF);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        drain();

        // Reset during WAIT abandons the store
        issue(1, 32'h020, 32'hCAFEF00D, 3'b010, 32'h0, 0, 0, 0, 1); drain();
        issue(1, 32'h020, 32'h11111111, 3'b010, 32'h0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        issue(0, 32'h020, 32'h0, 3'b010, 32'hCAFEF00D, 0, 0, 0, 1); drain();

        // Streaming loads: response spacing
        issue(0, 32'h010, 32'h0, 3'b010, 32'hABCDBEEF, 0, 0, 0, 1);
        issue(0, 32'h020, 32'h0, 3'b010, 32'hCAFEF00D, 0, 0, EXP_GAP, 1);
        issue(0, 32'h010, 32'h0, 3'b010, 32'hABCDBEEF, 0, 0, EXP_GAP, 1);
        issue(0, 32'h020, 32'h0, 3'b010, 32'hCAFEF00D, 0, 0, EXP_GAP, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the CPU data-memory path. It accepts load/store requests over a valid/ready handshake and models a byte-addressed, little-endian RAM with configurable access latency. It handles byte and halfword byte-lanes, sign/zero extension and alignment checking, then returns a response over a second valid/ready handshake. It lets the load/store path be verified against a multi-cycle memory instead of a single-cycle array.

Parameters:
DATA_WIDTH, 32, data and address width; only 32 supported.
ADDR_WIDTH, 12, byte-address bits decoded; memory = 2**ADDR_WIDTH bytes, organised as 2**(ADDR_WIDTH-2) words.
LATENCY, 2, wait cycles between request accept and memory access; legal range 1..15.

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  DATA_WIDTH  byte address
req_wdata  input  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0])
req_funct3  input  3  RISC-V load/store funct3
rsp_valid  output  1  response present
rsp_ready  input  1  initiator accepts response
rsp_rdata  output  DATA_WIDTH  load result, extended; 0 for stores and errors
rsp_err  output  1  misaligned access or illegal funct3

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, latency counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, captured request cleared. Memory contents are not reset.
- Reset mid-operation abandons the transaction. A store whose commit edge has not yet occurred is never written.
- FSM states:
  - IDLE: req_ready = 1. On req_valid & req_ready, capture we/addr/wdata/funct3, load counter with LATENCY-1, go to WAIT.
  - WAIT: req_ready = 0. Decrement the counter each cycle. When the counter is 0, perform the access at that edge and go to RESP.
  - RESP: rsp_valid = 1. rsp_rdata and rsp_err are registered and stable until rsp_ready = 1, then go to IDLE.
- Timing: cycle 0 is the accept cycle, cycles 1..LATENCY are WAIT, and rsp_valid is first high in cycle LATENCY+1. A store commits at the edge ending cycle LATENCY.
- rsp_valid never drops without rsp_ready. req_ready never depends combinationally on req_valid.
- Address: only req_addr[ADDR_WIDTH-1:0] is used; higher bits are ignored (aliasing/wrap).
- Loads by funct3:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
- Stores by funct3:
  - 000 SB: byte-enable for lane addr[1:0].
  - 001 SH: lanes addr[1]*2 and addr[1]*2+1.
  - 010 SW: all four lanes.
  - Unaffected bytes are preserved.
- Error conditions:
  - Halfword with addr[0] = 1.
  - Word with addr[1:0] != 0.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 not in {000, 001, 010}.
  - On error: no memory write, rsp_err = 1, rsp_rdata = 0. The full latency is still observed.
- Store response: rsp_rdata = 0, rsp_err per the checks above.
- Inputs are sampled only at accept; changes on req_* during WAIT/RESP are ignored.

Optional Feature:
DMEM_BACK_TO_BACK_EN
- Defined: in RESP, req_ready = rsp_ready. If rsp_ready & req_valid in the same cycle, the response retires and the new request is captured, going straight to WAIT. There is no IDLE bubble, so sustained throughput is 1 per LATENCY+1 cycles.
- Undefined: req_ready = 0 in RESP, and one IDLE cycle always separates transactions.

Test Plan:
- Reset, then SW addr 0x010, wdata 0xDEADBEEF, LATENCY=2, rsp_ready=1 -> rsp_valid first high in cycle 3, rsp_err=0, rsp_rdata=0. LW 0x010 -> rsp_rdata 0xDEADBEEF.
- SB 0x013, wdata 0x00000080 over word 0xDEADBEEF -> LW 0x010 returns 0x80ADBEEF. LB 0x013 -> 0xFFFFFF80. LBU 0x013 -> 0x00000080.
- SH 0x012, wdata 0x1234ABCD -> LW 0x010 returns 0xABCDBEEF. LH 0x012 -> 0xFFFFABCD. LHU 0x012 -> 0x0000ABCD.
- SW 0x011 and LH 0x013 -> rsp_err=1, rsp_rdata=0, memory at 0x010 unchanged. Load with funct3=011 -> rsp_err=1.
- Hold rsp_ready=0 for 5 cycles during RESP -> rsp_valid/rsp_rdata stable and req_ready=0. Assert rst_n=0 during WAIT of SW 0x020 wdata 0x11111111 -> LW 0x020 returns the prior contents.
- With DMEM_BACK_TO_BACK_EN: 4 consecutive LW with req_valid and rsp_ready held high -> responses spaced exactly LATENCY+1 cycles. Without the macro: spaced LATENCY+2 cycles.
